// File: rtl/linear_layer_start_token_fifo.sv
// Shift-register FIFO for start tokens and small control words between dataflow
// stages. Show-ahead: the head word is on if_dout whenever if_empty_n is high.
// Flags are registered from the next occupancy, so they change on the same edge as the count.
module linear_layer_start_token_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CntOne   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_n_q, full_n_q;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] raddr;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read & if_read_ce & empty_n_q;

  // Oldest word sits at the highest occupied index.
  assign raddr = ADDR_WIDTH'(count_q - CntOne);

  // Next occupancy from the qualified push/pop only.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Occupancy and flags; the flags follow the next count, never a cycle stale.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      empty_n_q <= (count_d != '0);
      full_n_q  <= (count_d != DepthCnt);
    end
  end

  // Storage shifts up on push; not reset, and a push during reset is dropped.
  always_ff @(posedge ap_clk) begin
    if (ap_rst_n && push) begin
      mem[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Head word, forced to zero when empty so the output is never undefined.
  always_comb begin
    if_dout = '0;
    if (count_q != '0) begin
      if_dout = mem[raddr];
    end
  end

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = DepthCnt;

  // The counter must never wrap in either direction.
  count_no_overflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (push && !pop) |-> (count_q != DepthCnt));

  count_no_underflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (pop && !push) |-> (count_q != '0));

  count_in_range: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    count_q <= DepthCnt);

endmodule

// File: tb/tb_linear_layer_start_token_fifo.sv
// Directed bench for linear_layer_start_token_fifo with DEPTH=2, DATA_WIDTH=4.
module tb_linear_layer_start_token_fifo;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 1;
  localparam int unsigned DP = 2;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic [DW-1:0] if_din;
  logic          if_full_n, if_empty_n;
  logic [DW-1:0] if_dout;
  logic [AW:0]   if_num_data_valid, if_fifo_cap;

  int tests  = 0;
  int errors = 0;

  linear_layer_start_token_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DP)
  ) dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .if_write_ce      (if_write_ce),
    .if_write         (if_write),
    .if_din           (if_din),
    .if_full_n        (if_full_n),
    .if_read_ce       (if_read_ce),
    .if_read          (if_read),
    .if_dout          (if_dout),
    .if_empty_n       (if_empty_n),
    .if_num_data_valid(if_num_data_valid),
    .if_fifo_cap      (if_fifo_cap)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    string         name;
    logic          rst_n;
    logic          wce;
    logic          w;
    logic [DW-1:0] din;
    logic          rce;
    logic          r;
    logic [DW-1:0] exp_dout;
    logic          exp_empty_n;
    logic          exp_full_n;
    logic [AW:0]   exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rst_n, input logic wce,
                              input logic w, input logic [DW-1:0] din, input logic rce,
                              input logic r, input logic [DW-1:0] dout, input logic en,
                              input logic fn, input logic [AW:0] cnt);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.wce = wce; v.w = w; v.din = din;
    v.rce = rce; v.r = r; v.exp_dout = dout; v.exp_empty_n = en;
    v.exp_full_n = fn; v.exp_count = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic wce, input logic w,
                       input logic [DW-1:0] din, input logic rce, input logic r);
    ap_rst_n = rst_n; if_write_ce = wce; if_write = w; if_din = din;
    if_read_ce = rce; if_read = r;
  endtask

  // Apply inputs, take one edge, then sample #1 later.
  task automatic step_check(input vec_t v);
    drive(v.rst_n, v.wce, v.w, v.din, v.rce, v.r);
    @(posedge ap_clk);
    #1;
    check({v.name, ".dout"},    32'(if_dout),           32'(v.exp_dout));
    check({v.name, ".empty_n"}, 32'(if_empty_n),        32'(v.exp_empty_n));
    check({v.name, ".full_n"},  32'(if_full_n),         32'(v.exp_full_n));
    check({v.name, ".count"},   32'(if_num_data_valid), 32'(v.exp_count));
  endtask

  initial begin
    //                 name           rst wce w  din   rce r  dout  en fn cnt
    vecs.push_back(mk("reset",        0,  0,  0, 4'h0, 0,  0, 4'h0, 0, 1, 2'd0));
    vecs.push_back(mk("idle",         1,  0,  0, 4'h0, 0,  0, 4'h0, 0, 1, 2'd0));
    vecs.push_back(mk("push3",        1,  1,  1, 4'h3, 1,  0, 4'h3, 1, 1, 2'd1));
    vecs.push_back(mk("push5",        1,  1,  1, 4'h5, 1,  0, 4'h3, 1, 0, 2'd2));
    vecs.push_back(mk("push7_full",   1,  1,  1, 4'h7, 1,  0, 4'h3, 1, 0, 2'd2));
    vecs.push_back(mk("pop_a",        1,  1,  0, 4'h0, 1,  1, 4'h5, 1, 1, 2'd1));
    vecs.push_back(mk("pop_b",        1,  1,  0, 4'h0, 1,  1, 4'h0, 0, 1, 2'd0));
    vecs.push_back(mk("pop_empty",    1,  1,  0, 4'h0, 1,  1, 4'h0, 0, 1, 2'd0));
    vecs.push_back(mk("pushA",        1,  1,  1, 4'hA, 1,  0, 4'hA, 1, 1, 2'd1));
    vecs.push_back(mk("pushB_pop",    1,  1,  1, 4'hB, 1,  1, 4'hB, 1, 1, 2'd1));
    vecs.push_back(mk("wce0_a",       1,  0,  1, 4'hC, 1,  1, 4'h0, 0, 1, 2'd0));
    vecs.push_back(mk("wce0_b",       1,  0,  1, 4'hC, 1,  1, 4'h0, 0, 1, 2'd0));
    vecs.push_back(mk("wce0_c",       1,  0,  1, 4'hC, 1,  1, 4'h0, 0, 1, 2'd0));
    vecs.push_back(mk("push1",        1,  1,  1, 4'h1, 1,  0, 4'h1, 1, 1, 2'd1));
    vecs.push_back(mk("push2",        1,  1,  1, 4'h2, 1,  0, 4'h1, 1, 0, 2'd2));
    vecs.push_back(mk("rce0_a",       1,  1,  0, 4'h0, 0,  1, 4'h1, 1, 0, 2'd2));
    vecs.push_back(mk("rce0_b",       1,  1,  0, 4'h0, 0,  1, 4'h1, 1, 0, 2'd2));
    vecs.push_back(mk("pop_1",        1,  1,  0, 4'h0, 1,  1, 4'h2, 1, 1, 2'd1));
    vecs.push_back(mk("rce0_push3",   1,  1,  1, 4'h3, 0,  1, 4'h2, 1, 0, 2'd2));
    vecs.push_back(mk("rst_mid",      0,  1,  1, 4'h9, 1,  1, 4'h0, 0, 1, 2'd0));
    vecs.push_back(mk("push4_post",   1,  1,  1, 4'h4, 1,  0, 4'h4, 1, 1, 2'd1));
    vecs.push_back(mk("push6",        1,  1,  1, 4'h6, 1,  0, 4'h4, 1, 0, 2'd2));
    vecs.push_back(mk("full_pushpop", 1,  1,  1, 4'h8, 1,  1, 4'h6, 1, 1, 2'd1));
    vecs.push_back(mk("pop_last",     1,  1,  0, 4'h0, 1,  1, 4'h0, 0, 1, 2'd0));

    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge ap_clk);
    #1;

    foreach (vecs[k]) begin
      step_check(vecs[k]);
      if (k == 0) check("fifo_cap", 32'(if_fifo_cap), 32'(DP));
    end

    // Sustained push+pop at count=1: each pop returns the previous word, none dropped.
    drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
    @(posedge ap_clk);
    #1;
    check("stream.preload", 32'(if_dout), 32'h0);
    for (int i = 1; i <= 20; i++) begin
      check("stream.head", 32'(if_dout), 32'((i - 1) & 15));
      drive(1'b1, 1'b1, 1'b1, DW'(i), 1'b1, 1'b1);
      @(posedge ap_clk);
      #1;
      check("stream.count", 32'(if_num_data_valid), 32'd1);
      check("stream.flags", 32'({if_empty_n, if_full_n}), 32'b11);
    end
    check("stream.tail", 32'(if_dout), 32'h4);

    // Drain the last word.
    drive(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    @(posedge ap_clk);
    #1;
    check("drain.count", 32'(if_num_data_valid), 32'd0);
    check("drain.empty_n", 32'(if_empty_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/linear_layer_start_token_fifo.md
Name: linear_layer_start_token_fifo

Overview:
- Shift-register FIFO controller carrying start tokens (and small control words) between dataflow processes of the Linear_Layer_i4xi4_q design, e.g. from the feeder stage into a PE_i4xi4_pack_2x2 instance.
- Owns a DEPTH-entry shift array, the read-address/occupancy counter and the registered full/empty flags.
- Exposes the standard HLS FIFO write/read handshake on both sides.
- Show-ahead (first-word-fall-through): the head word is visible on if_dout whenever if_empty_n=1.

Parameters:
- DATA_WIDTH, 1, token/word width in bits.
- ADDR_WIDTH, 1, read-address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- DEPTH, 2, number of storage entries; legal range 1..2^ADDR_WIDTH.

Ports:
- ap_clk  in  1  single clock; all state updates on its rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- if_write_ce  in  1  write-side clock enable; a push requires it high.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  registered; 1 = space available.
- if_read_ce  in  1  read-side clock enable; a pop requires it high.
- if_read  in  1  read request.
- if_dout  out  DATA_WIDTH  head-of-queue word, combinational from storage.
- if_empty_n  out  1  registered; 1 = data available.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

Behaviour:
- push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n. Requests while the FIFO is full (push) or empty (pop) are ignored; no state changes.
- Storage: on push, all entries shift up by one and entry 0 takes if_din. Storage is not reset.
- Head read address = count-1; oldest word sits at the highest occupied index.
- if_dout = storage[count-1] when count>0, else all-zero. The zero gating keeps the bench deterministic.
- Counter updates, per rising edge (count is ADDR_WIDTH+1 bits):
  - push only: count+1
  - pop only: count-1
  - push and pop: count unchanged, storage shifts
  - neither: hold
- Simultaneous push+pop with count=1: after the edge, if_dout shows the newly pushed word and count stays 1.
- Flags are registered from next-count in the same edge as count, so they are never a cycle stale:
  - if_empty_n <= (next_count != 0)
  - if_full_n <= (next_count != DEPTH)
- if_num_data_valid = count.
- Latency: a word pushed into an empty FIFO is visible on if_dout, with if_empty_n=1, in the cycle after the push edge. Pop takes effect at the edge; the next word is visible the following cycle.
- Throughput: one push and one pop per cycle sustained, including at count=DEPTH-1 and count=1.
- DEPTH=1: the FIFO alternates full/empty, and simultaneous push+pop is impossible because the flags block one side.
- Reset (ap_rst_n=0 at an edge, including mid-operation):
  - count = 0, if_empty_n = 0, if_full_n = 1, if_dout = 0 from the next cycle.
  - Any push or pop in the reset cycle is discarded.
- Either clock enable low suppresses that side only. The other side still operates, and the counter uses only the qualified push/pop.
- Counter must never wrap: no increment at DEPTH, no decrement at 0. Assertions on both belong in the RTL.

Test Plan:
- Reset then idle, DEPTH=2, DATA_WIDTH=4 -> if_empty_n=0, if_full_n=1, if_num_data_valid=0, if_dout=0, if_fifo_cap=2.
- Push 0x3 then 0x5 on consecutive cycles -> after the 2nd edge count=2, if_full_n=0, if_dout=0x3. A third push of 0x7 is ignored: count stays 2.
- From full, pop twice -> if_dout shows 0x3, then 0x5, then 0 with if_empty_n=0. A further pop is ignored and count stays 0.
- Count=1 holding 0xA; push 0xB and pop in the same cycle -> count=1, if_dout=0xB, flags unchanged. Sustain 20 cycles of push+pop with an incrementing pattern -> output order matches input, no drops.
- if_write_ce=0 with if_write=1 for 3 cycles, while reads proceed with if_read_ce=1 -> no pushes, pops drain to empty. Then the mirror case, if_read_ce=0 with if_read=1 -> no pops.
- Fill to 2, assert ap_rst_n=0 for one cycle together with if_write=1 and if_read=1 -> next cycle count=0, if_empty_n=0, if_full_n=1. A push right after reset deasserts is accepted normally.
